// File: rtl/cpu_bus_responder.sv
// CPU-bus responder: mirrored internal RAM, PPU register window, controller ports, OAM DMA, cartridge pass-through.
// Optional macro DMA_ODD_ALIGN_EN: a DMA started on an odd cycle gets a second alignment cycle.
module cpu_bus_responder #(
    parameter int         RAM_AW   = 11,
    parameter int         JOY_BITS = 8,
    parameter logic [2:0] OAM_REG  = 3'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        write,
    input  logic [7:0]  d_out,
    output logic [7:0]  cpu_din,
    output logic        ready,
    output logic        ppu_sel,
    output logic [2:0]  ppu_reg,
    output logic        ppu_wr,
    output logic [7:0]  ppu_wdata,
    input  logic [7:0]  ppu_rdata,
    output logic        cart_sel,
    output logic        cart_wr,
    input  logic [7:0]  cart_rdata,
    input  logic [7:0]  joy1,
    input  logic [7:0]  joy2
);

    // state  | meaning
    // IDLE   | CPU owns the bus
    // ALIGN2 | extra alignment cycle for odd-cycle starts (optional)
    // ALIGN  | dummy cycle before the first DMA read
    // RD     | DMA reads {page, cnt}
    // WR     | DMA writes the byte to OAMDATA, cnt++
`ifdef DMA_ODD_ALIGN_EN
    typedef enum logic [2:0] {S_IDLE, S_ALIGN2, S_ALIGN, S_RD, S_WR} dma_state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RD, S_WR} dma_state_t;
`endif
    typedef enum logic [2:0] {R_NONE, R_RAM, R_PPU, R_DMA, R_JOY1, R_JOY2, R_CART} region_t;
    typedef enum logic [1:0] {SRC_HOLD, SRC_RAM, SRC_PPU, SRC_CART} src_t;

    function automatic region_t decode(input logic [15:0] a);
        if (a[15:13] == 3'b000) return R_RAM;
        if (a[15:13] == 3'b001) return R_PPU;
        if (a == 16'h4014)      return R_DMA;
        if (a == 16'h4016)      return R_JOY1;
        if (a == 16'h4017)      return R_JOY2;
        if (a >= 16'h4020)      return R_CART;
        return R_NONE;
    endfunction

    logic [7:0]          ram [2**RAM_AW];
    logic [7:0]          ram_q;
    dma_state_t          state_q, state_nxt;
    logic [7:0]          cnt_q, cnt_nxt, page_q, page_nxt;
    src_t                cpu_src_q, dma_src_q;
    logic [7:0]          hold_q, dma_byte;
    logic                strobe_q;
    logic [JOY_BITS-1:0] sr1_q, sr2_q;
    logic                dma_rd, dma_wr, cpu_rd, cpu_wr, bus_act;
    logic [15:0]         bus_addr;
    region_t             region;
`ifdef DMA_ODD_ALIGN_EN
    logic                parity_q;
`endif

    always_comb begin
        ready     = (state_q == S_IDLE);
        dma_rd    = (state_q == S_RD);
        dma_wr    = (state_q == S_WR);
        bus_addr  = dma_rd ? {page_q, cnt_q} : addr;
        region    = decode(bus_addr);
        cpu_rd    = ready && !write && !reset;
        cpu_wr    = ready && write && !reset;
        bus_act   = (ready || dma_rd) && !reset;
        ppu_sel   = !reset && (dma_wr || (bus_act && region == R_PPU));
        ppu_reg   = dma_wr ? OAM_REG : bus_addr[2:0];
        ppu_wr    = !reset && (dma_wr || (cpu_wr && region == R_PPU));
        ppu_wdata = dma_wr ? dma_byte : d_out;
        cart_sel  = bus_act && region == R_CART;
        cart_wr   = cpu_wr && region == R_CART;
    end

    // cpu_din is the open-bus latch unless the previous cycle read a live source
    always_comb begin
        case (cpu_src_q)
            SRC_RAM:  cpu_din = ram_q;
            SRC_PPU:  cpu_din = ppu_rdata;
            SRC_CART: cpu_din = cart_rdata;
            default:  cpu_din = hold_q;
        endcase
        case (dma_src_q)
            SRC_RAM:  dma_byte = ram_q;
            SRC_PPU:  dma_byte = ppu_rdata;
            SRC_CART: dma_byte = cart_rdata;
            default:  dma_byte = hold_q;
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        page_nxt  = page_q;
        case (state_q)
            S_IDLE: if (cpu_wr && region == R_DMA) begin
                page_nxt  = d_out;
                cnt_nxt   = 8'h00;
                state_nxt = S_ALIGN;
`ifdef DMA_ODD_ALIGN_EN
                if (parity_q) state_nxt = S_ALIGN2;
`endif
            end
`ifdef DMA_ODD_ALIGN_EN
            S_ALIGN2: state_nxt = S_ALIGN;
`endif
            S_ALIGN: state_nxt = S_RD;
            S_RD:    state_nxt = S_WR;
            S_WR: begin
                cnt_nxt   = cnt_q + 8'd1;
                state_nxt = (cnt_q == 8'hFF) ? S_IDLE : S_RD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'h00;
            page_q    <= 8'h00;
            cpu_src_q <= SRC_HOLD;
            dma_src_q <= SRC_HOLD;
            hold_q    <= 8'h00;
            strobe_q  <= 1'b0;
            sr1_q     <= '0;
            sr2_q     <= '0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            page_q    <= page_nxt;
            hold_q    <= cpu_din;
            cpu_src_q <= SRC_HOLD;
            if (strobe_q) begin
                sr1_q <= JOY_BITS'(joy1);
                sr2_q <= JOY_BITS'(joy2);
            end
            if (cpu_rd) begin
                case (region)
                    R_RAM:  cpu_src_q <= SRC_RAM;
                    R_PPU:  cpu_src_q <= SRC_PPU;
                    R_CART: cpu_src_q <= SRC_CART;
                    R_JOY1: begin
                        hold_q <= {7'b0, strobe_q ? joy1[0] : sr1_q[0]};
                        if (!strobe_q) sr1_q <= {1'b1, sr1_q[JOY_BITS-1:1]};
                    end
                    R_JOY2: begin
                        hold_q <= {7'b0, strobe_q ? joy2[0] : sr2_q[0]};
                        if (!strobe_q) sr2_q <= {1'b1, sr2_q[JOY_BITS-1:1]};
                    end
                    default: ;
                endcase
            end
            if (cpu_wr && region == R_JOY1) strobe_q <= d_out[0];
            if (dma_rd) begin
                case (region)
                    R_RAM:   dma_src_q <= SRC_RAM;
                    R_PPU:   dma_src_q <= SRC_PPU;
                    R_CART:  dma_src_q <= SRC_CART;
                    default: dma_src_q <= SRC_HOLD;
                endcase
            end
        end
    end

`ifdef DMA_ODD_ALIGN_EN
    always_ff @(posedge clk) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= ~parity_q;
    end
`endif

    // RAM is deliberately outside the reset domain; contents survive reset
    always_ff @(posedge clk) begin
        if (cpu_wr && region == R_RAM) ram[bus_addr[RAM_AW-1:0]] <= d_out;
        ram_q <= ram[bus_addr[RAM_AW-1:0]];
    end

endmodule
